dsp_reset_seq: RTL and testbench

Parametrised DSP reset and detection engine for the CT2960 riser. It drives the Sound Blaster DSP reset protocol over the riser's ISA transaction port: write 1 to the reset port, hold for a programmable pulse, write 0, poll read-buffer status, then read the 0xAA ready byte. Compared with the fixed single-shot sequencer, it adds a start/done handshake, poll timeout with bounded retries, failure reporting, and an optional DSP version read. It sits between the host-side control logic and the ISA bus transaction master.

---
 rtl/dsp_reset_seq_pkg.sv | 47 ++++
 rtl/dsp_cycle_timer.sv | 27 ++
 rtl/dsp_reset_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_dsp_reset_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_reset_seq_pkg.sv
// Shared constants, FSM state encoding and bus-operation payload for the DSP reset/detect engine.
package dsp_reset_seq_pkg;

    localparam logic [3:0] PORT_RESET       = 4'h6;
    localparam logic [3:0] PORT_READ_DATA   = 4'hA;
    localparam logic [3:0] PORT_WRITE_CMD   = 4'hC;
    localparam logic [3:0] PORT_READ_STATUS = 4'hE;

    localparam logic [7:0] DSP_READY       = 8'hAA;
    localparam logic [7:0] DSP_CMD_VERSION = 8'hE1;
    localparam logic [7:0] DSP_RESET_ON    = 8'h01;
    localparam logic [7:0] DSP_RESET_OFF   = 8'h00;

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] ST_WR1      = 4'd1;
    localparam logic [STATE_W-1:0] ST_PULSE    = 4'd2;
    localparam logic [STATE_W-1:0] ST_WR0      = 4'd3;
    localparam logic [STATE_W-1:0] ST_POLL_ST  = 4'd4;
    localparam logic [STATE_W-1:0] ST_RD_DATA  = 4'd5;
    localparam logic [STATE_W-1:0] ST_VER_WST  = 4'd6;
    localparam logic [STATE_W-1:0] ST_VER_CMD  = 4'd7;
    localparam logic [STATE_W-1:0] ST_VER_RST1 = 4'd8;
    localparam logic [STATE_W-1:0] ST_VER_RD1  = 4'd9;
    localparam logic [STATE_W-1:0] ST_VER_RST2 = 4'd10;
    localparam logic [STATE_W-1:0] ST_VER_RD2  = 4'd11;
    localparam logic [STATE_W-1:0] ST_DONE     = 4'd12;
    localparam logic [STATE_W-1:0] ST_FAIL     = 4'd13;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } dsp_bus_op_t;

    // Builds one ISA transaction relative to the DSP base address.
    function automatic dsp_bus_op_t dsp_op(input logic we, input logic [15:0] base,
                                           input logic [3:0] offset, input logic [7:0] data);
        dsp_bus_op_t op;
        op.we   = we;
        op.addr = base + 16'(offset);
        op.data = data;
        return op;
    endfunction

endpackage

// File: rtl/dsp_cycle_timer.sv
// Loadable down-counter with terminal-count flag; counts only while enabled and saturates at zero.
module dsp_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         sys_clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         tc_c
);

    logic [W-1:0] count;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc_c = (count == '0);

endmodule

// File: rtl/dsp_reset_seq.sv
// Sound Blaster DSP reset/detect engine with start/done handshake, poll timeout and bounded retries.
// Optional DSP version read after detection is enabled by defining DSP_VERSION_READ_EN.
module dsp_reset_seq
    import dsp_reset_seq_pkg::*;
#(
    parameter logic [15:0] BASE_ADDRESS = 16'h0220,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned PULSE_CYCLES = 150,
    parameter int unsigned POLL_TIMEOUT = 5000,
    parameter int unsigned MAX_RETRIES  = 3,
    localparam int unsigned RETRY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               sys_clock,
    input  logic               reset_n,
    input  logic               start,
    output logic               bus_req,
    output logic               bus_we,
    output logic [15:0]        bus_addr,
    output logic [DATA_W-1:0]  bus_wdata,
    input  logic               bus_ack,
    input  logic [DATA_W-1:0]  bus_rdata,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [RETRY_W-1:0] retries_used,
    output logic [15:0]        dsp_version
);

    localparam int unsigned PULSE_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES + 1) : 1;
    // WR0 state entry plus its one-cycle request latency absorbs two cycles of the hold.
    localparam int unsigned PULSE_LOAD = (PULSE_CYCLES >= 2) ? PULSE_CYCLES - 2 : 0;
    localparam int unsigned POLL_W     = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT + 1) : 1;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               bus_req_nxt;
    logic               bus_we_nxt;
    logic [15:0]        bus_addr_nxt;
    logic [DATA_W-1:0]  bus_wdata_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               fail_nxt;
    logic [RETRY_W-1:0] retries_nxt;
    logic [15:0]        version_nxt;

    dsp_bus_op_t        op_c;
    logic               xfer_c;
    logic               bus_state_c;
    logic               poll_state_c;
    logic               pulse_load_c;
    logic               pulse_en_c;
    logic               pulse_tc_c;
    logic               poll_load_c;
    logic               poll_tc_c;
    logic               unused_rdata;

    // Only bits [7:0] carry DSP data; wider buses are accepted and the rest ignored.
    assign unused_rdata = ^bus_rdata;

    assign xfer_c     = bus_req && bus_ack;
    assign pulse_en_c = (state == ST_PULSE);

    dsp_cycle_timer #(.W(PULSE_W)) u_pulse_timer (
        .sys_clock  (sys_clock),
        .reset_n    (reset_n),
        .load       (pulse_load_c),
        .load_value (PULSE_W'(PULSE_LOAD)),
        .enable     (pulse_en_c),
        .tc_c       (pulse_tc_c)
    );

    dsp_cycle_timer #(.W(POLL_W)) u_poll_timer (
        .sys_clock  (sys_clock),
        .reset_n    (reset_n),
        .load       (poll_load_c),
        .load_value (POLL_W'(POLL_TIMEOUT)),
        .enable     (poll_state_c),
        .tc_c       (poll_tc_c)
    );

    // State and registered outputs.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            retries_used <= '0;
            dsp_version  <= '0;
        end else begin
            state        <= state_nxt;
            bus_req      <= bus_req_nxt;
            bus_we       <= bus_we_nxt;
            bus_addr     <= bus_addr_nxt;
            bus_wdata    <= bus_wdata_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            fail         <= fail_nxt;
            retries_used <= retries_nxt;
            dsp_version  <= version_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        bus_req_nxt   = bus_req;
        bus_we_nxt    = bus_we;
        bus_addr_nxt  = bus_addr;
        bus_wdata_nxt = bus_wdata;
        retries_nxt   = retries_used;
        version_nxt   = dsp_version;
        op_c          = '0;
        bus_state_c   = 1'b0;
        poll_state_c  = 1'b0;
        pulse_load_c  = 1'b0;
        poll_load_c   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_nxt   = ST_WR1;
                    retries_nxt = '0;
                    version_nxt = '0;
                end
            end
            ST_WR1: begin
                bus_state_c = 1'b1;
                op_c        = dsp_op(1'b1, BASE_ADDRESS, PORT_RESET, DSP_RESET_ON);
                if (xfer_c) begin
                    state_nxt    = ST_PULSE;
                    pulse_load_c = 1'b1;
                end
            end
            ST_PULSE: begin
                if (pulse_tc_c) begin
                    state_nxt = ST_WR0;
                end
            end
            ST_WR0: begin
                bus_state_c = 1'b1;
                op_c        = dsp_op(1'b1, BASE_ADDRESS, PORT_RESET, DSP_RESET_OFF);
                if (xfer_c) begin
                    state_nxt   = ST_POLL_ST;
                    poll_load_c = 1'b1;
                end
            end
            ST_POLL_ST: begin
                bus_state_c  = 1'b1;
                poll_state_c = 1'b1;
                op_c         = dsp_op(1'b0, BASE_ADDRESS, PORT_READ_STATUS, 8'h00);
                if (xfer_c && bus_rdata[7]) begin
                    state_nxt = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                bus_state_c  = 1'b1;
                poll_state_c = 1'b1;
                op_c         = dsp_op(1'b0, BASE_ADDRESS, PORT_READ_DATA, 8'h00);
                if (xfer_c) begin
                    if (bus_rdata[7:0] == DSP_READY) begin
`ifdef DSP_VERSION_READ_EN
                        state_nxt = ST_VER_WST;
`else
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        state_nxt = ST_POLL_ST;
                    end
                end
            end
`ifdef DSP_VERSION_READ_EN
            ST_VER_WST: begin
                bus_state_c  = 1'b1;
                poll_state_c = 1'b1;
                op_c         = dsp_op(1'b0, BASE_ADDRESS, PORT_WRITE_CMD, 8'h00);
                if (xfer_c && !bus_rdata[7]) begin
                    state_nxt = ST_VER_CMD;
                end
            end
            ST_VER_CMD: begin
                bus_state_c  = 1'b1;
                poll_state_c = 1'b1;
                op_c         = dsp_op(1'b1, BASE_ADDRESS, PORT_WRITE_CMD, DSP_CMD_VERSION);
                if (xfer_c) begin
                    state_nxt = ST_VER_RST1;
                end
            end
            ST_VER_RST1: begin
                bus_state_c  = 1'b1;
                poll_state_c = 1'b1;
                op_c         = dsp_op(1'b0, BASE_ADDRESS, PORT_READ_STATUS, 8'h00);
                if (xfer_c && bus_rdata[7]) begin
                    state_nxt = ST_VER_RD1;
                end
            end
            ST_VER_RD1: begin
                bus_state_c  = 1'b1;
                poll_state_c = 1'b1;
                op_c         = dsp_op(1'b0, BASE_ADDRESS, PORT_READ_DATA, 8'h00);
                if (xfer_c) begin
                    version_nxt[15:8] = bus_rdata[7:0];
                    state_nxt         = ST_VER_RST2;
                end
            end
            ST_VER_RST2: begin
                bus_state_c  = 1'b1;
                poll_state_c = 1'b1;
                op_c         = dsp_op(1'b0, BASE_ADDRESS, PORT_READ_STATUS, 8'h00);
                if (xfer_c && bus_rdata[7]) begin
                    state_nxt = ST_VER_RD2;
                end
            end
            ST_VER_RD2: begin
                bus_state_c  = 1'b1;
                poll_state_c = 1'b1;
                op_c         = dsp_op(1'b0, BASE_ADDRESS, PORT_READ_DATA, 8'h00);
                if (xfer_c) begin
                    version_nxt[7:0] = bus_rdata[7:0];
                    state_nxt        = ST_DONE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // One transaction at a time, with an idle cycle after every ack.
        if (bus_state_c) begin
            if (xfer_c) begin
                bus_req_nxt = 1'b0;
            end else if (!bus_req && !(poll_state_c && poll_tc_c)) begin
                bus_req_nxt   = 1'b1;
                bus_we_nxt    = op_c.we;
                bus_addr_nxt  = op_c.addr;
                bus_wdata_nxt = DATA_W'(op_c.data);
            end
        end

        // Timeout overrides any normal transition once the bus is quiet.
        if (poll_state_c && poll_tc_c && (!bus_req || xfer_c)) begin
            version_nxt = dsp_version;
            if (retries_used < RETRY_W'(MAX_RETRIES)) begin
                retries_nxt = retries_used + RETRY_W'(1);
                state_nxt   = ST_WR1;
            end else begin
                state_nxt = ST_FAIL;
            end
        end

        busy_nxt = !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE) || (state_nxt == ST_FAIL));
        done_nxt = (state_nxt == ST_DONE);
        fail_nxt = (state_nxt == ST_FAIL);
    end

endmodule

// File: tb/tb_dsp_reset_seq.sv
// Directed bench for dsp_reset_seq: scripted ISA responder, write log and hand-computed expectations.
module tb_dsp_reset_seq;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned PULSE_CYCLES = 150;
    localparam int unsigned POLL_TIMEOUT = 400;
    localparam int unsigned MAX_RETRIES  = 2;
`ifdef DSP_VERSION_READ_EN
    localparam int          EXP_WR       = 3;
    localparam int          EXP_DRD      = 2;
    localparam int          EXP_ST1      = 9;
    localparam logic [15:0] EXP_VER      = 16'h040D;
`else
    localparam int          EXP_WR       = 2;
    localparam int          EXP_DRD      = 0;
    localparam int          EXP_ST1      = 3;
    localparam logic [15:0] EXP_VER      = 16'h0000;
`endif

    logic              sys_clock = 1'b0;
    logic              reset_n   = 1'b0;
    logic              start     = 1'b0;
    logic              bus_req;
    logic              bus_we;
    logic [15:0]       bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack   = 1'b0;
    logic [DATA_W-1:0] bus_rdata = '0;
    logic              busy;
    logic              done;
    logic              fail;
    logic [1:0]        retries_used;
    logic [15:0]       dsp_version;

    dsp_reset_seq #(
        .BASE_ADDRESS (16'h0220),
        .DATA_W       (DATA_W),
        .PULSE_CYCLES (PULSE_CYCLES),
        .POLL_TIMEOUT (POLL_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .sys_clock    (sys_clock),
        .reset_n      (reset_n),
        .start        (start),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .retries_used (retries_used),
        .dsp_version  (dsp_version)
    );

    always #5 sys_clock = ~sys_clock;

    int cyc = 0;
    always @(posedge sys_clock) cyc <= cyc + 1;

    // Responder-owned state
    int          wr_n         = 0;
    logic [15:0] wr_addr [64];
    logic [7:0]  wr_data [64];
    int          wr_req_cyc [64];
    int          wr_ack_cyc [64];
    int          data_idx     = 0;
    int          status_reads = 0;
    int          polls        = 0;
    int          wait_cnt     = 0;
    int          req_cyc      = 0;

    // Test-owned responder script
    int          dead_mode    = 0;
    int          ready_after  = 1;
    int          seq_base     = 0;
    logic [7:0]  data_seq [4];

    int n_cmp = 0;
    int n_mis = 0;
    int start_cyc = 0;
    int wr_base, st_base, dat_base, ones;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ISA slave: acks on the second cycle of each request.
    initial begin
        forever begin
            @(negedge sys_clock);
            if (!reset_n) begin
                bus_ack  = 1'b0;
                wait_cnt = 0;
            end else if (bus_ack) begin
                bus_ack = 1'b0;
            end else if (bus_req) begin
                if (wait_cnt == 0) req_cyc = cyc;
                if (wait_cnt == 1) begin
                    wait_cnt = 0;
                    bus_ack  = 1'b1;
                    if (bus_we) begin
                        if (wr_n < 64) begin
                            wr_addr[wr_n]    = bus_addr;
                            wr_data[wr_n]    = bus_wdata[7:0];
                            wr_req_cyc[wr_n] = req_cyc;
                            wr_ack_cyc[wr_n] = cyc;
                        end
                        wr_n++;
                        polls = 0;
                    end else begin
                        case (bus_addr)
                            16'h022E: begin
                                status_reads++;
                                polls++;
                                bus_rdata = (dead_mode == 0 && polls >= ready_after) ? 16'hA580 : 16'h5A00;
                            end
                            16'h022A: begin
                                bus_rdata = {8'hA5, data_seq[(data_idx - seq_base) > 3 ? 3 : (data_idx - seq_base)]};
                                data_idx++;
                                polls = 0;
                            end
                            16'h022C: bus_rdata = 16'h7F00;
                            default:  bus_rdata = 16'hFFFF;
                        endcase
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic setup(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input int ready, input int dead);
        @(negedge sys_clock);
        data_seq[0] = d0;
        data_seq[1] = d1;
        data_seq[2] = d2;
        data_seq[3] = d3;
        seq_base    = data_idx;
        ready_after = ready;
        dead_mode   = dead;
        wr_base     = wr_n;
        st_base     = status_reads;
        dat_base    = data_idx;
    endtask

    task automatic start_pulse;
        @(negedge sys_clock);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge sys_clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge sys_clock);
            n++;
        end
        check({tag, "_finished"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
        check({tag, "_bus_we"}, 32'(bus_we), 32'd0);
        check({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
        check({tag, "_bus_wdata"}, 32'(bus_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_retries"}, 32'(retries_used), 32'd0);
        check({tag, "_version"}, 32'(dsp_version), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge sys_clock);
        check_reset_values("por");
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clock);

        // Responsive DSP: ready on third status poll
        setup(8'hAA, 8'h04, 8'h0D, 8'h00, 3, 0);
        start_pulse();
        wait_idle(3000, "resp");
        check("resp_latency", 32'(wr_req_cyc[wr_base] - start_cyc), 32'd2);
        check("resp_wr_count", 32'(wr_n - wr_base), 32'(EXP_WR));
        check("resp_wr1_addr", 32'(wr_addr[wr_base]), 32'h226);
        check("resp_wr1_data", 32'(wr_data[wr_base]), 32'h01);
        check("resp_wr0_addr", 32'(wr_addr[wr_base + 1]), 32'h226);
        check("resp_wr0_data", 32'(wr_data[wr_base + 1]), 32'h00);
        check("resp_pulse_gap", 32'(wr_req_cyc[wr_base + 1] - wr_ack_cyc[wr_base]), 32'(PULSE_CYCLES + 1));
        check("resp_status_reads", 32'(status_reads - st_base), 32'(EXP_ST1));
        check("resp_done", 32'(done), 32'd1);
        check("resp_fail", 32'(fail), 32'd0);
        check("resp_retries", 32'(retries_used), 32'd0);
        check("resp_version", 32'(dsp_version), 32'(EXP_VER));
`ifdef DSP_VERSION_READ_EN
        check("ver_cmd_addr", 32'(wr_addr[wr_base + 2]), 32'h22C);
        check("ver_cmd_data", 32'(wr_data[wr_base + 2]), 32'hE1);
`endif

        // Wrong first data byte: polling resumes, no retry
        setup(8'h55, 8'hAA, 8'h04, 8'h0D, 1, 0);
        start_pulse();
        wait_idle(3000, "wrong");
        check("wrong_done", 32'(done), 32'd1);
        check("wrong_retries", 32'(retries_used), 32'd0);
        check("wrong_wr_count", 32'(wr_n - wr_base), 32'(EXP_WR));
        check("wrong_data_reads", 32'(data_idx - dat_base), 32'(2 + EXP_DRD));
        check("wrong_version", 32'(dsp_version), 32'(EXP_VER));

        // Dead DSP: three full sequences then failure
        setup(8'hAA, 8'h04, 8'h0D, 8'h00, 1, 1);
        start_pulse();
        wait_idle(5000, "dead");
        ones = 0;
        for (int i = wr_base; i < wr_n && i < 64; i++) begin
            if (wr_data[i] == 8'h01) ones++;
        end
        check("dead_fail", 32'(fail), 32'd1);
        check("dead_done", 32'(done), 32'd0);
        check("dead_retries", 32'(retries_used), 32'd2);
        check("dead_wr_count", 32'(wr_n - wr_base), 32'd6);
        check("dead_reset_pulses", 32'(ones), 32'd3);
        check("dead_bus_req", 32'(bus_req), 32'd0);

        // Start while busy is ignored
        setup(8'hAA, 8'h04, 8'h0D, 8'h00, 1, 0);
        start_pulse();
        repeat (20) @(negedge sys_clock);
        start_pulse();
        repeat (5) @(negedge sys_clock);
        check("busy_still_busy", 32'(busy), 32'd1);
        check("busy_no_restart", 32'(wr_n - wr_base), 32'd1);
        wait_idle(3000, "busy");
        check("busy_done", 32'(done), 32'd1);
        check("busy_fail_cleared", 32'(fail), 32'd0);
        check("busy_wr_count", 32'(wr_n - wr_base), 32'(EXP_WR));

        // Reset pulsed mid-PULSE, then a clean rerun
        setup(8'hAA, 8'h04, 8'h0D, 8'h00, 1, 0);
        start_pulse();
        repeat (40) @(negedge sys_clock);
        check("rst_in_pulse_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (3) @(negedge sys_clock);
        reset_n = 1'b1;
        check("midrst_idle_wr", 32'(wr_n - wr_base), 32'd1);
        setup(8'hAA, 8'h04, 8'h0D, 8'h00, 2, 0);
        start_pulse();
        wait_idle(3000, "rerun");
        check("rerun_latency", 32'(wr_req_cyc[wr_base] - start_cyc), 32'd2);
        check("rerun_wr_count", 32'(wr_n - wr_base), 32'(EXP_WR));
        check("rerun_gap", 32'(wr_req_cyc[wr_base + 1] - wr_ack_cyc[wr_base]), 32'(PULSE_CYCLES + 1));
        check("rerun_done", 32'(done), 32'd1);
        check("rerun_retries", 32'(retries_used), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
